// File: rtl/sprite_fetch.sv
// Pixel-pipeline reader for one 40x40 sprite ROM: latches the position once per frame, addresses the ROM, emits color+valid 3 clocks after DrawX/DrawY.
// Optional macro SPRITE_FETCH_TRANSPARENCY_EN: ROM words equal to KEY_COLOR are emitted as transparent.
module sprite_fetch #(
   parameter int          SPR_W     = 40,
   parameter int          SPR_H     = 40,
   parameter int          ADDR_W    = 13,
   parameter int          COORD_W   = 10,
   parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] sprite_x,
   input  logic [COORD_W-1:0] sprite_y,
   input  logic               sprite_en,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   output logic [ADDR_W-1:0]  read_address,
   input  logic [23:0]        data_In,
   output logic [23:0]        pixel_color,
   output logic               pixel_valid
);

   localparam int CW1 = COORD_W + 1;

   logic [COORD_W-1:0] r_sx;
   logic [COORD_W-1:0] r_sy;
   logic               r_sen;
   logic               r_hit1;
   logic               r_hit2;
   logic [ADDR_W-1:0]  r_addr;
   logic [23:0]        r_color;
   logic               r_valid;

   logic [CW1-1:0]     w_x_ext;
   logic [CW1-1:0]     w_y_ext;
   logic [CW1-1:0]     w_sx_ext;
   logic [CW1-1:0]     w_sy_ext;
   logic [CW1-1:0]     w_sx_end;
   logic [CW1-1:0]     w_sy_end;
   logic               w_hit;
   logic [COORD_W-1:0] w_dx;
   logic [COORD_W-1:0] w_dy;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_key;
   logic               w_valid_next;

   // One extra bit keeps sx+SPR_W from wrapping when the sprite hangs off the right/bottom edge.
   assign w_x_ext  = {1'b0, DrawX};
   assign w_y_ext  = {1'b0, DrawY};
   assign w_sx_ext = {1'b0, r_sx};
   assign w_sy_ext = {1'b0, r_sy};
   assign w_sx_end = w_sx_ext + CW1'(SPR_W);
   assign w_sy_end = w_sy_ext + CW1'(SPR_H);

   assign w_hit = r_sen
                  && (w_x_ext >= w_sx_ext) && (w_x_ext < w_sx_end)
                  && (w_y_ext >= w_sy_ext) && (w_y_ext < w_sy_end);

   assign w_dx   = DrawX - r_sx;
   assign w_dy   = DrawY - r_sy;
   assign w_addr = w_hit ? (ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_dx)) : '0;

`ifdef SPRITE_FETCH_TRANSPARENCY_EN
   assign w_key = (data_In == KEY_COLOR);
`else
   assign w_key = 1'b0;
`endif

   assign w_valid_next = r_hit2 && !w_key;

   // Shadow position only moves at frame_start; the hit test on that same edge still sees the old values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sx  <= '0;
         r_sy  <= '0;
         r_sen <= 1'b0;
      end else if (frame_start) begin
         r_sx  <= sprite_x;
         r_sy  <= sprite_y;
         r_sen <= sprite_en;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_addr  <= '0;
         r_hit1  <= 1'b0;
         r_hit2  <= 1'b0;
         r_valid <= 1'b0;
         r_color <= '0;
      end else begin
         r_addr  <= w_addr;
         r_hit1  <= w_hit;
         r_hit2  <= r_hit1;
         r_valid <= w_valid_next;
         r_color <= w_valid_next ? data_In : 24'h000000;
      end
   end

   assign read_address = r_addr;
   assign pixel_color  = r_color;
   assign pixel_valid  = r_valid;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed testbench for sprite_fetch with a registered-read ROM model.
`timescale 1ns/1ps
module tb_sprite_fetch;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic [9:0]  sprite_x;
   logic [9:0]  sprite_y;
   logic        sprite_en;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic [12:0] read_address;
   logic [23:0] rom_q;
   logic [23:0] pixel_color;
   logic        pixel_valid;

   int errors = 0;
   int checks = 0;

   sprite_fetch dut (
      .Clk          (clk),
      .Reset_n      (rst_n),
      .frame_start  (frame_start),
      .sprite_x     (sprite_x),
      .sprite_y     (sprite_y),
      .sprite_en    (sprite_en),
      .DrawX        (draw_x),
      .DrawY        (draw_y),
      .read_address (read_address),
      .data_In      (rom_q),
      .pixel_color  (pixel_color),
      .pixel_valid  (pixel_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: 0x100000 | addr, except the key color planted at address 5.
   function automatic logic [23:0] rom_word(input logic [12:0] a);
      if (a == 13'd5) return 24'hFF00FF;
      return {11'h080, a};
   endfunction

   always @(posedge clk) rom_q <= rom_word(read_address);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_sprite(input logic [9:0] x, input logic [9:0] y, input logic en);
      sprite_x = x; sprite_y = y; sprite_en = en;
      draw_x = 10'd0; draw_y = 10'd0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_start = 1'b0;
      sprite_x = 10'd0; sprite_y = 10'd0; sprite_en = 1'b0;
      draw_x = 10'd0; draw_y = 10'd0;
      #1;
      checks++;
      if (read_address !== 13'd0 || pixel_valid !== 1'b0 || pixel_color !== 24'h0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%0d valid=%b color=%h required 0/0/000000", read_address, pixel_valid, pixel_color);
      end
      step(); step();
      rst_n = 1'b1;
      draw_x = 10'd0; draw_y = 10'd0;
      step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b0 || read_address !== 13'd0) begin
         errors++;
         $display("FAIL reset_no_sprite: valid=%b addr=%0d required 0/0", pixel_valid, read_address);
      end
      $display("test_reset done");
   endtask

   task automatic test_corners();
      load_sprite(10'd100, 10'd50, 1'b1);
      draw_x = 10'd100; draw_y = 10'd50;
      step();
      checks++;
      if (read_address !== 13'd0) begin
         errors++; $display("FAIL top_left_addr: got %0d required 0", read_address);
      end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_color !== 24'h100000) begin
         errors++; $display("FAIL top_left_pixel: valid=%b color=%h required 1/100000", pixel_valid, pixel_color);
      end
      draw_x = 10'd139; draw_y = 10'd89;
      step();
      checks++;
      if (read_address !== 13'd1599) begin
         errors++; $display("FAIL bottom_right_addr: got %0d required 1599", read_address);
      end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_color !== 24'h10063F) begin
         errors++; $display("FAIL bottom_right_pixel: valid=%b color=%h required 1/10063f", pixel_valid, pixel_color);
      end
      draw_x = 10'd140; draw_y = 10'd89;
      step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b0 || pixel_color !== 24'h0 || read_address !== 13'd0) begin
         errors++; $display("FAIL right_edge_miss: valid=%b color=%h addr=%0d required 0/000000/0", pixel_valid, pixel_color, read_address);
      end
      draw_x = 10'd139; draw_y = 10'd90;
      step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b0 || pixel_color !== 24'h0 || read_address !== 13'd0) begin
         errors++; $display("FAIL bottom_edge_miss: valid=%b color=%h addr=%0d required 0/000000/0", pixel_valid, pixel_color, read_address);
      end
      $display("test_corners done");
   endtask

   task automatic test_raster_line();
      int addr_err = 0, color_err = 0, vcount = 0, first = -1, last = -1;
      logic [12:0] exp_addr;
      draw_y = 10'd60;
      for (int k = 0; k < 642; k++) begin
         draw_x = 10'(k);
         step();
         exp_addr = (k >= 100 && k < 140) ? 13'(400 + k - 100) : 13'd0;
         if (read_address !== exp_addr) addr_err++;
         if (pixel_valid === 1'b1) begin
            vcount++;
            if (first < 0) first = k - 2;
            last = k - 2;
            if (pixel_color !== rom_word(13'(400 + k - 2 - 100))) color_err++;
         end
      end
      checks++;
      if (vcount != 40) begin errors++; $display("FAIL raster_count: got %0d required 40", vcount); end
      checks++;
      if (first != 100 || last != 139) begin
         errors++; $display("FAIL raster_span: got %0d..%0d required 100..139", first, last);
      end
      checks++;
      if (addr_err != 0) begin errors++; $display("FAIL raster_addr: %0d wrong addresses required 0", addr_err); end
      checks++;
      if (color_err != 0) begin errors++; $display("FAIL raster_color: %0d wrong colors required 0", color_err); end
      $display("test_raster_line done");
   endtask

   task automatic test_shadow();
      sprite_x = 10'd300;
      draw_x = 10'd100; draw_y = 10'd50;
      step();
      checks++;
      if (read_address !== 13'd0) begin errors++; $display("FAIL shadow_hold_addr: got %0d required 0", read_address); end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_color !== 24'h100000) begin
         errors++; $display("FAIL shadow_hold_pixel: valid=%b color=%h required 1/100000", pixel_valid, pixel_color);
      end
      // frame_start on the same edge as a hit: old position still applies to that pixel
      draw_x = 10'd101; draw_y = 10'd50;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checks++;
      if (read_address !== 13'd1) begin errors++; $display("FAIL same_edge_old_pos: got %0d required 1", read_address); end
      step();
      checks++;
      if (read_address !== 13'd0) begin errors++; $display("FAIL new_pos_miss: got %0d required 0", read_address); end
      draw_x = 10'd301;
      step();
      checks++;
      if (read_address !== 13'd1) begin errors++; $display("FAIL new_pos_hit: got %0d required 1", read_address); end
      draw_x = 10'd300;
      step();
      checks++;
      if (read_address !== 13'd0) begin errors++; $display("FAIL new_pos_origin_addr: got %0d required 0", read_address); end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_color !== 24'h100000) begin
         errors++; $display("FAIL new_pos_origin_pixel: valid=%b color=%h required 1/100000", pixel_valid, pixel_color);
      end
      $display("test_shadow done");
   endtask

   task automatic test_key_color();
      logic        exp_v;
      logic [23:0] exp_c;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
      exp_v = 1'b0; exp_c = 24'h000000;
`else
      exp_v = 1'b1; exp_c = 24'hFF00FF;
`endif
      load_sprite(10'd100, 10'd50, 1'b1);
      draw_x = 10'd105; draw_y = 10'd50;
      step();
      checks++;
      if (read_address !== 13'd5) begin errors++; $display("FAIL key_addr: got %0d required 5", read_address); end
      step(); step();
      checks++;
      if (pixel_valid !== exp_v || pixel_color !== exp_c) begin
         errors++; $display("FAIL key_pixel: valid=%b color=%h required %b/%h", pixel_valid, pixel_color, exp_v, exp_c);
      end
      $display("test_key_color done");
   endtask

   task automatic test_offscreen_and_disable();
      load_sprite(10'd1000, 10'd50, 1'b1);
      draw_x = 10'd1023; draw_y = 10'd51;
      step();
      checks++;
      if (read_address !== 13'd63) begin errors++; $display("FAIL offscreen_hit_addr: got %0d required 63", read_address); end
      draw_x = 10'd5;
      step();
      checks++;
      if (read_address !== 13'd0) begin errors++; $display("FAIL offscreen_no_wrap: got %0d required 0", read_address); end
      step(); step();
      checks++;
      if (pixel_valid !== 1'b0) begin errors++; $display("FAIL offscreen_no_wrap_valid: got %b required 0", pixel_valid); end
      load_sprite(10'd100, 10'd50, 1'b0);
      draw_x = 10'd110; draw_y = 10'd60;
      step(); step(); step();
      checks++;
      if (read_address !== 13'd0 || pixel_valid !== 1'b0) begin
         errors++; $display("FAIL disabled: addr=%0d valid=%b required 0/0", read_address, pixel_valid);
      end
      $display("test_offscreen_and_disable done");
   endtask

   task automatic test_reset_mid_line();
      load_sprite(10'd100, 10'd50, 1'b1);
      draw_x = 10'd110; draw_y = 10'd60;
      step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b required 1", pixel_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (read_address !== 13'd0 || pixel_valid !== 1'b0 || pixel_color !== 24'h0) begin
         errors++; $display("FAIL async_reset: addr=%0d valid=%b color=%h required 0/0/000000", read_address, pixel_valid, pixel_color);
      end
      step();
      rst_n = 1'b1;
      step(); step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b0 || read_address !== 13'd0) begin
         errors++; $display("FAIL post_reset_invisible: valid=%b addr=%0d required 0/0", pixel_valid, read_address);
      end
      load_sprite(10'd100, 10'd50, 1'b1);
      draw_x = 10'd110; draw_y = 10'd60;
      step(); step(); step();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_color !== rom_word(13'd410)) begin
         errors++; $display("FAIL post_reset_reload: valid=%b color=%h required 1/%h", pixel_valid, pixel_color, rom_word(13'd410));
      end
      $display("test_reset_mid_line done");
   endtask

   initial begin
      test_reset();
      test_corners();
      test_raster_line();
      test_shadow();
      test_key_color();
      test_offscreen_and_disable();
      test_reset_mid_line();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Pixel-pipeline reader for the 40x40 on-chip sprite ROMs (24-bit RGB, 1600 words, one-cycle registered read). Takes the VGA controller's current DrawX/DrawY and a sprite position latched once per frame, generates the ROM read address, aligns the returned word with a hit flag, and emits a registered color plus valid flag to the color mapper. One instance sits in front of each sprite ROM (note gems, fret markers).

## Interface
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- ADDR_W, 13, ROM address width
- COORD_W, 10, DrawX/DrawY and sprite position width
- KEY_COLOR, 24'hFF00FF, transparent color key
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank; latches the position
- sprite_x  in  COORD_W  sprite left column (live value)
- sprite_y  in  COORD_W  sprite top row (live value)
- sprite_en  in  1  sprite visible this frame (live value)
- DrawX  in  COORD_W  current pixel column
- DrawY  in  COORD_W  current pixel row
- read_address  out  ADDR_W  to ROM read_address
- data_In  in  24  from ROM data_Out; valid one clock after read_address
- pixel_color  out  24  sprite color for the pixel sampled 3 clocks earlier
- pixel_valid  out  1  pixel_color is opaque sprite data

## Operation
- Shadow registers sx, sy, sen load sprite_x, sprite_y, sprite_en on any cycle with frame_start=1. Live inputs are otherwise ignored, so the sprite never tears mid-frame.
- Hit test, with all compares in COORD_W+1 bits and no wrap: sen && DrawX>=sx && DrawX<sx+SPR_W && DrawY>=sy && DrawY<sy+SPR_H.
- On a hit: address = (DrawY-sy)*SPR_W + (DrawX-sx), truncated to ADDR_W and always below SPR_W*SPR_H. On a miss, the address is 0.
- Stage 1 (edge E0): register read_address and hit1.
- Stage 2 (edge E1): the ROM registers data_In; hit2 <= hit1.
- Stage 3 (edge E2): pixel_valid <= hit2 (subject to the key rule below); pixel_color <= data_In if pixel_valid is next 1, else 0.
- frame_start and pixel traffic on the same edge: shadow regs update, and the hit test on that edge uses the old shadow values.

## Timing
- Latency: DrawX/DrawY sampled at E0, so pixel_color/pixel_valid are valid after E2 (3 clocks). The color mapper delays hsync/vsync/blank by 3 clocks to match.
- Throughput: one pixel per clock, no stalls, no handshake.
- Reset (Reset_n=0, asynchronous): read_address=0, pixel_color=0, pixel_valid=0, hit1=hit2=0, sx=sy=0, sen=0.
  - Sprite stays invisible until the first frame_start after release.
  - Reset asserted mid-line flushes the pipeline immediately; no stale pixel emerges after release.
- Sprite partially off-screen (sx+SPR_W>1023): the widened compare prevents wrap, and only on-screen columns hit.
- sen=0: read_address stays 0 and pixel_valid stays 0 for the whole frame.

## Configuration
- SPRITE_FETCH_TRANSPARENCY_EN defined:
  - At stage 3, data_In==KEY_COLOR forces pixel_valid=0 and pixel_color=0 even when hit2=1.
- Not defined:
  - Every hit pixel is valid, including KEY_COLOR words, and the whole 40x40 box is drawn.

## Test plan
- Reset, then frame_start with sprite_x=100, sprite_y=50, sprite_en=1; DrawX=100, DrawY=50 → read_address=0 after 1 clock; pixel_valid=1 and pixel_color=mem[0] after 3 clocks.
- Same sprite, DrawX=139, DrawY=89 → address 1599. DrawX=140 or DrawY=90 → pixel_valid=0, pixel_color=0.
- Raster scan of a full line y=60 from x=0..639 → pixel_valid high for exactly 40 consecutive cycles; addresses run 400..439.
- sprite_x changed to 300 mid-frame without frame_start → output unchanged. After frame_start, a hit at DrawX=300 gives address 0.
- ROM word 24'hFF00FF at address 5 → pixel_valid=0 with SPRITE_FETCH_TRANSPARENCY_EN; pixel_valid=1 and color FF00FF without it.
- Reset_n pulsed low while inside the sprite box → outputs 0 immediately. After release, no valid pixel appears until the next frame_start.
